// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one data memory between the core load/store port (p0) and the
// loader/DMA port (p1). Each access is sequenced IDLE -> ISSUE -> RESP. The
// request is sampled in IDLE. Memory strobes are driven in ISSUE. The
// completion pulse goes to the granted port in RESP. Accesses with a bad size
// code or an out-of-range word address never touch memory and complete with
// err=1. When both ports ask in the same IDLE cycle, a round-robin pointer
// picks the winner, so neither port waits for more than one access.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   pN_req/we/size/        request level, direction, size code, word address
//   pN_addr/wdata          and write data for port N (held until pN_ack)
//   pN_ack/err/rdata       one-cycle completion, illegal flag, read data
//   mem_read/mem_write     memory strobes (ISSUE cycle only)
//   mem_size/addr/wdata    memory command fields (valid with a strobe)
//   mem_rdata              memory read data, valid the cycle after mem_read
//   busy                   high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_WORDS = 64,
    parameter int FIRST_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [2:0]  p0_size,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [2:0]  p1_size,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,

    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    localparam logic [31:0] ADDR_LIMIT = 32'(ADDR_WORDS);
    localparam logic        FIRST_PTR  = (FIRST_PRIO != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        ptr_reg,   ptr_next;    // port that wins the next tie
    logic        gnt_reg,   gnt_next;    // port owning the current access
    logic        we_reg,    we_next;
    logic [2:0]  size_reg,  size_next;
    logic [31:0] addr_reg,  addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        err_reg,   err_next;    // access rejected at grant time

    // Request fields gathered into per-port arrays so that the grant mux
    // and the response fan-out are written once for both ports.
    logic [1:0]  req_vec;
    logic [1:0]  we_vec;
    logic [2:0]  size_arr  [2];
    logic [31:0] addr_arr  [2];
    logic [31:0] wdata_arr [2];

    logic [1:0]  ack_vec;
    logic [1:0]  err_vec;
    logic [31:0] rdata_arr [2];

    assign req_vec      = {p1_req, p0_req};
    assign we_vec       = {p1_we,  p0_we};
    assign size_arr[0]  = p0_size;
    assign size_arr[1]  = p1_size;
    assign addr_arr[0]  = p0_addr;
    assign addr_arr[1]  = p1_addr;
    assign wdata_arr[0] = p0_wdata;
    assign wdata_arr[1] = p1_wdata;

    // Legal codes: 001/010/011 for reads and writes, 101/110 for reads only.
    // Unsigned codes only affect read extension, so they are meaningless
    // (and rejected) on a write.
    function automatic logic is_illegal(input logic        we,
                                        input logic [2:0]  size,
                                        input logic [31:0] addr);
        logic bad;
        bad = 1'b0;
        case (size)
            3'b000, 3'b100, 3'b111: bad = 1'b1;
            3'b101, 3'b110:         bad = we;
            default:                bad = 1'b0;
        endcase
        if (addr >= ADDR_LIMIT) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= FIRST_PTR;
            gnt_reg   <= 1'b0;
            we_reg    <= 1'b0;
            size_reg  <= 3'b000;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= gnt_next;
            we_reg    <= we_next;
            size_reg  <= size_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            err_reg   <= err_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: arbitration and field capture happen in IDLE only,
    // so the latched command stays constant through ISSUE and RESP.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        gnt_next   = gnt_reg;
        we_next    = we_reg;
        size_next  = size_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        err_next   = err_reg;

        case (state_reg)
            IDLE: begin
                if (req_vec != 2'b00) begin
                    if (req_vec == 2'b11) begin
                        gnt_next = ptr_reg;
                    end else begin
                        gnt_next = req_vec[1];
                    end
                    // Whoever did not get this access wins the next tie.
                    ptr_next   = ~gnt_next;
                    we_next    = we_vec[gnt_next];
                    size_next  = size_arr[gnt_next];
                    addr_next  = addr_arr[gnt_next];
                    wdata_next = wdata_arr[gnt_next];
                    err_next   = is_illegal(we_vec[gnt_next],
                                            size_arr[gnt_next],
                                            addr_arr[gnt_next]);
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory command: only a legal access in ISSUE reaches the memory.
    // Fields are forced to zero otherwise so the bus is quiet when idle.
    // ------------------------------------------------------------------
    logic issue_ok;
    logic resp_now;

    assign issue_ok  = (state_reg == ISSUE) && !err_reg;
    assign resp_now  = (state_reg == RESP);

    assign mem_read  = issue_ok && !we_reg;
    assign mem_write = issue_ok &&  we_reg;
    assign mem_size  = issue_ok ? size_reg  : 3'b000;
    assign mem_addr  = issue_ok ? addr_reg  : 32'd0;
    assign mem_wdata = issue_ok ? wdata_reg : 32'd0;

    assign busy      = (state_reg != IDLE);

    // ------------------------------------------------------------------
    // Response fan-out. The memory registers its read data on the ISSUE
    // edge, so mem_rdata is passed straight through during RESP.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign ack_vec[gi]   = resp_now && (gnt_reg == 1'(gi));
            assign err_vec[gi]   = ack_vec[gi] && err_reg;
            assign rdata_arr[gi] = (ack_vec[gi] && !err_reg && !we_reg)
                                   ? mem_rdata : 32'd0;
        end
    endgenerate

    assign p0_ack   = ack_vec[0];
    assign p0_err   = err_vec[0];
    assign p0_rdata = rdata_arr[0];
    assign p1_ack   = ack_vec[1];
    assign p1_err   = err_vec[1];
    assign p1_rdata = rdata_arr[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter with a 64-word data memory model. The model has a
// registered read that performs sign/zero extension by size code, and it
// writes the low byte, half or full word. A table of single-port accesses
// is applied and checked cycle by cycle: ISSUE strobes and fields, then the
// RESP ack/err/rdata, then the return to idle. Hand-written sequences cover
// round-robin ties, the pointer after a single grant, and reset in ISSUE.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we;
    logic [2:0]  p0_size;
    logic [31:0] p0_addr, p0_wdata;
    logic        p0_ack, p0_err;
    logic [31:0] p0_rdata;
    logic        p1_req, p1_we;
    logic [2:0]  p1_size;
    logic [31:0] p1_addr, p1_wdata;
    logic        p1_ack, p1_err;
    logic [31:0] p1_rdata;
    logic        mem_read, mem_write;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WORDS(64), .FIRST_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [64];
    logic        mem_init_done = 1'b0;

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] sz);
        case (sz)
            3'b001:  return {{24{w[7]}}, w[7:0]};
            3'b101:  return {24'd0, w[7:0]};
            3'b010:  return {{16{w[15]}}, w[15:0]};
            3'b110:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset && !mem_init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
            mem[3]        <= 32'h33333333;
            mem[5]        <= 32'hDEADBEEF;
            mem[7]        <= 32'h77770007;
            mem[63]       <= 32'hA5A50063;
            mem_rdata     <= 32'd0;
            mem_init_done <= 1'b1;
        end else begin
            if (mem_write) begin
                case (mem_size)
                    3'b001, 3'b101: mem[mem_addr[5:0]][7:0]  <= mem_wdata[7:0];
                    3'b010, 3'b110: mem[mem_addr[5:0]][15:0] <= mem_wdata[15:0];
                    default:        mem[mem_addr[5:0]]       <= mem_wdata;
                endcase
            end
            if (mem_read) mem_rdata <= ext(mem[mem_addr[5:0]], mem_size);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [21];

    // One single-port access: ISSUE check, RESP check, idle check.
    task automatic run_vec(input vec_t v, input int idx);
        logic own_ack, oth_ack, own_err;
        logic [31:0] own_rdata;
        @(negedge clk);
        if (v.port == 1'b0) begin
            p0_req = 1'b1; p0_we = v.we; p0_size = v.size; p0_addr = v.addr; p0_wdata = v.wdata;
        end else begin
            p1_req = 1'b1; p1_we = v.we; p1_size = v.size; p1_addr = v.addr; p1_wdata = v.wdata;
        end
        @(posedge clk);
        @(negedge clk);
        chk1($sformatf("v%0d_issue_busy", idx), busy, 1'b1);
        chk1($sformatf("v%0d_issue_read", idx), mem_read, !v.exp_err && !v.we);
        chk1($sformatf("v%0d_issue_write", idx), mem_write, !v.exp_err && v.we);
        if (!v.exp_err) begin
            chk($sformatf("v%0d_issue_addr", idx), mem_addr, v.addr);
            chk($sformatf("v%0d_issue_size", idx), {29'd0, mem_size}, {29'd0, v.size});
            if (v.we) chk($sformatf("v%0d_issue_wdata", idx), mem_wdata, v.wdata);
        end
        chk1($sformatf("v%0d_issue_noack", idx), p0_ack | p1_ack, 1'b0);
        @(negedge clk);
        own_ack   = v.port ? p1_ack   : p0_ack;
        oth_ack   = v.port ? p0_ack   : p1_ack;
        own_err   = v.port ? p1_err   : p0_err;
        own_rdata = v.port ? p1_rdata : p0_rdata;
        chk1($sformatf("v%0d_ack", idx), own_ack, 1'b1);
        chk1($sformatf("v%0d_other_ack", idx), oth_ack, 1'b0);
        chk1($sformatf("v%0d_err", idx), own_err, v.exp_err);
        chk($sformatf("v%0d_rdata", idx), own_rdata, v.exp_rdata);
        chk1($sformatf("v%0d_resp_strobes", idx), mem_read | mem_write, 1'b0);
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(negedge clk);
        chk1($sformatf("v%0d_idle_busy", idx), busy, 1'b0);
        chk1($sformatf("v%0d_idle_ack", idx), p0_ack | p1_ack, 1'b0);
        $display("vec %0d: port=%0d we=%0d size=%b addr=%h -> err=%0d rdata=%h",
                 idx, v.port, v.we, v.size, v.addr, own_err, own_rdata);
    endtask

    // One access with requests already held; called just before the sampling edge.
    task automatic rr_txn(input string tag, input logic exp_port,
                          input logic [31:0] exp_addr, input logic [31:0] exp_rdata);
        @(posedge clk);
        @(negedge clk);
        chk1({tag, "_issue_read"}, mem_read, 1'b1);
        chk1({tag, "_issue_write"}, mem_write, 1'b0);
        chk({tag, "_issue_addr"}, mem_addr, exp_addr);
        @(negedge clk);
        chk1({tag, "_p0_ack"}, p0_ack, !exp_port);
        chk1({tag, "_p1_ack"}, p1_ack, exp_port);
        chk({tag, "_rdata"}, exp_port ? p1_rdata : p0_rdata, exp_rdata);
        chk1({tag, "_resp_strobes"}, mem_read | mem_write, 1'b0);
        @(negedge clk);
        chk1({tag, "_idle_busy"}, busy, 1'b0);
        $display("%s: granted p%0d addr=%h", tag, exp_port, exp_addr);
    endtask

    task automatic hold_both();
        p0_req = 1'b1; p0_we = 1'b0; p0_size = 3'b011; p0_addr = 32'd5; p0_wdata = 32'd0;
        p1_req = 1'b1; p1_we = 1'b0; p1_size = 3'b011; p1_addr = 32'd7; p1_wdata = 32'd0;
    endtask

    initial begin
        logic ack_seen;

        vecs[0]  = '{1'b0, 1'b0, 3'b011, 32'd5,        32'd0,         1'b0, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b1, 3'b001, 32'd10,       32'h12345678,  1'b0, 32'h00000000};
        vecs[2]  = '{1'b1, 1'b0, 3'b011, 32'd10,       32'd0,         1'b0, 32'h00000078};
        vecs[3]  = '{1'b0, 1'b0, 3'b001, 32'd10,       32'd0,         1'b0, 32'h00000078};
        vecs[4]  = '{1'b0, 1'b1, 3'b011, 32'd20,       32'h800080F0,  1'b0, 32'h00000000};
        vecs[5]  = '{1'b0, 1'b0, 3'b001, 32'd20,       32'd0,         1'b0, 32'hFFFFFFF0};
        vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'd20,       32'd0,         1'b0, 32'h000000F0};
        vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'd20,       32'd0,         1'b0, 32'hFFFF80F0};
        vecs[8]  = '{1'b0, 1'b0, 3'b110, 32'd20,       32'd0,         1'b0, 32'h000080F0};
        vecs[9]  = '{1'b0, 1'b0, 3'b100, 32'd3,        32'd0,         1'b1, 32'h00000000};
        vecs[10] = '{1'b1, 1'b1, 3'b101, 32'd3,        32'hFFFFFFFF,  1'b1, 32'h00000000};
        vecs[11] = '{1'b0, 1'b0, 3'b011, 32'd64,       32'd0,         1'b1, 32'h00000000};
        vecs[12] = '{1'b1, 1'b0, 3'b011, 32'd63,       32'd0,         1'b0, 32'hA5A50063};
        vecs[13] = '{1'b1, 1'b1, 3'b110, 32'd4,        32'h11111111,  1'b1, 32'h00000000};
        vecs[14] = '{1'b0, 1'b0, 3'b000, 32'd4,        32'd0,         1'b1, 32'h00000000};
        vecs[15] = '{1'b1, 1'b0, 3'b111, 32'd4,        32'd0,         1'b1, 32'h00000000};
        vecs[16] = '{1'b0, 1'b1, 3'b010, 32'd63,       32'h00001234,  1'b0, 32'h00000000};
        vecs[17] = '{1'b1, 1'b0, 3'b011, 32'd63,       32'd0,         1'b0, 32'hA5A51234};
        vecs[18] = '{1'b0, 1'b0, 3'b011, 32'hFFFFFFFF, 32'd0,         1'b1, 32'h00000000};
        vecs[19] = '{1'b1, 1'b1, 3'b011, 32'd64,       32'hCAFEF00D,  1'b1, 32'h00000000};
        vecs[20] = '{1'b0, 1'b0, 3'b011, 32'd3,        32'd0,         1'b0, 32'h33333333};

        reset = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_size = 3'b000; p0_addr = 32'd0; p0_wdata = 32'd0;
        p1_req = 1'b0; p1_we = 1'b0; p1_size = 3'b000; p1_addr = 32'd0; p1_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_strobes", mem_read | mem_write, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_size", {29'd0, mem_size}, 32'd0);
        chk("rst_acks_errs", {28'd0, p0_ack, p0_err, p1_ack, p1_err}, 32'd0);
        chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);
        reset = 1'b0;

        // Tie held for four accesses: p0, p1, p0, p1, each 3 cycles apart.
        @(negedge clk);
        hold_both();
        rr_txn("rr0", 1'b0, 32'd5, 32'hDEADBEEF);
        rr_txn("rr1", 1'b1, 32'd7, 32'h77770007);
        rr_txn("rr2", 1'b0, 32'd5, 32'hDEADBEEF);
        rr_txn("rr3", 1'b1, 32'd7, 32'h77770007);
        p0_req = 1'b0;
        p1_req = 1'b0;

        for (int i = 0; i < 21; i++) run_vec(vecs[i], i);

        // Last single grant went to p0, so p1 wins the next tie.
        @(negedge clk);
        hold_both();
        rr_txn("ptr0", 1'b1, 32'd7, 32'h77770007);
        rr_txn("ptr1", 1'b0, 32'd5, 32'hDEADBEEF);
        p0_req = 1'b0;
        p1_req = 1'b0;

        // Reset during ISSUE of a p0 read abandons the access.
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b0; p0_size = 3'b011; p0_addr = 32'd5;
        @(posedge clk);
        @(negedge clk);
        chk1("mid_issue_read", mem_read, 1'b1);
        reset  = 1'b1;
        p0_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk1("mid_busy", busy, 1'b0);
        chk1("mid_strobes", mem_read | mem_write, 1'b0);
        chk1("mid_ack", p0_ack | p1_ack, 1'b0);
        reset = 1'b0;
        ack_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            ack_seen = ack_seen | p0_ack | p1_ack;
        end
        chk1("mid_no_late_ack", ack_seen, 1'b0);
        $display("reset-in-issue: busy=%0d ack_seen=%0d", busy, ack_seen);

        // Pointer is back at port 0 after reset.
        hold_both();
        rr_txn("post_rst", 1'b0, 32'd5, 32'hDEADBEEF);
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the data memory.
- Shares the single data memory between the core load/store port (p0) and a loader/DMA port (p1).
- Drives the memory's read/write strobes, word address, write data and 3-bit access-size code. Returns read data and completion to the granted requester.
- Rejects illegal accesses without touching memory. Round-robin arbitration guarantees neither port starves.

Parameters:
ADDR_WORDS, 64, number of 32-bit words in data memory; word addresses >= ADDR_WORDS are illegal
FIRST_PRIO, 0, port given priority first after reset (0 or 1)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
p0_req  input  1  port 0 request; level, held until p0_ack
p0_we  input  1  port 0 write (1) / read (0)
p0_size  input  3  port 0 size code: 001 signed byte, 010 signed half, 011 word, 101 unsigned byte, 110 unsigned half
p0_addr  input  32  port 0 word address
p0_wdata  input  32  port 0 write data
p0_ack  output  1  port 0 completion pulse (1 cycle)
p0_err  output  1  port 0 illegal-access flag, valid with p0_ack
p0_rdata  output  32  port 0 read data, valid with p0_ack on legal reads
p1_req, p1_we, p1_size, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata  same as port 0, for port 1
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_size  output  3  memory size code (DATA_MEM_In)
mem_addr  output  32  memory word address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data; registered by memory, valid the cycle after the read strobe
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- FSM states: IDLE, ISSUE, RESP.
- Reset:
  - State goes to IDLE and the round-robin pointer is set to FIRST_PRIO.
  - All outputs go to 0: mem_read, mem_write, mem_size, mem_addr, mem_wdata, both ack/err/rdata, and busy.
- IDLE:
  - At each edge, sample p0_req and p1_req.
  - One requester: grant it.
  - Both requesters: grant the port named by the pointer, then toggle the pointer to the other port.
  - Single grant: set the pointer to the non-granted port.
  - On grant, latch that port's we/size/addr/wdata into registers and go to ISSUE.
- Legality check at grant time:
  - Illegal if size is in {000, 100, 111}.
  - Illegal if we=1 and size is in {101, 110}.
  - Illegal if addr >= ADDR_WORDS.
- ISSUE, legal access:
  - mem_read = ~we and mem_write = we, driven from registers.
  - mem_size, mem_addr and mem_wdata are driven from the latched values.
  - Go to RESP.
- ISSUE, illegal access: both strobes stay 0 and the FSM goes to RESP with the error flag set.
- RESP:
  - Assert ack on the granted port for exactly one cycle.
  - Legal read: rdata = mem_rdata.
  - Illegal access: err=1 and rdata=0.
  - Write: rdata=0, err=0.
  - Strobes are 0. Go to IDLE.
- Non-granted port: ack, err and rdata are all 0 at all times.
- Latency: request sampled at edge k gives ISSUE in cycle k+1 and ack in cycle k+2. Throughput is one access per 3 cycles.
- Requester protocol:
  - Requester must deassert req in the cycle after ack.
  - req still high at the IDLE sampling edge is a new request.
  - Fields must be stable from req assertion until ack.
- Simultaneous requests: the loser keeps req high and is granted in the next IDLE. Maximum wait is one access (3 cycles).
- No sign/zero extension in this block; the memory performs it per the size code.
- Reset mid-operation (ISSUE or RESP): the FSM goes to IDLE at that edge and strobes drop. No ack is issued and the access is abandoned; a write issued in ISSUE may already have landed.

Test Plan:
- Reset, then p0 read addr=5 size=011 with memory word 5 = 0xDEADBEEF → mem_read high in cycle k+1 only, p0_ack in cycle k+2, p0_rdata=0xDEADBEEF, p0_err=0.
- p1 write addr=10 size=001 wdata=0x12345678 → mem_write for one cycle with mem_size=001, mem_addr=10, mem_wdata=0x12345678; p1_ack with err=0; a following p1 read of addr 10, size 011, returns 0x00000078.
- p0 and p1 request together, held for 4 transactions, FIRST_PRIO=0 → grant order p0, p1, p0, p1; acks 3 cycles apart; no overlapping strobes.
- Illegal accesses (read size=100; write size=101; read addr=64) → no mem_read/mem_write ever asserted; ack with err=1 and rdata=0 at k+2.
- Reset asserted during ISSUE of a p0 read → next cycle IDLE, busy=0, no p0_ack; a fresh p0 request afterwards completes normally with pointer at FIRST_PRIO.
